// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC and sequences FETCH -> WAIT -> ISSUE -> EXEC,
// presenting a NOP word to the control unit except during the single ISSUE cycle.
module instr_fetch_unit #(
   parameter int                     PC_WIDTH    = 8,
   parameter int                     INSTR_WIDTH = 10,
   parameter int                     ROM_LATENCY = 1,        // legal range 1..4
   parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 10'h3C0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   load_PC,
   input  logic [PC_WIDTH-1:0]    pc_value,
   output logic [PC_WIDTH-1:0]    imem_addr,
   output logic                   imem_en,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   halted,
   output logic [15:0]            instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_EXEC
   } state_t;

   state_t                 state, state_next;
   logic [2:0]             wait_cnt;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   wait_done;

   assign wait_done = (wait_cnt == 3'd1);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (run) state_next = S_FETCH;
         S_FETCH: state_next = S_WAIT;
         S_WAIT:  if (wait_done) state_next = S_ISSUE;
         S_ISSUE: state_next = S_EXEC;
         S_EXEC:  state_next = run ? S_FETCH : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= '0;
         ir          <= NOP_WORD;
         pc          <= '0;
         instr_count <= '0;
      end else begin
         unique case (state)
            S_FETCH: wait_cnt <= 3'(ROM_LATENCY);
            S_WAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (wait_done) ir <= imem_rdata;
            end
            S_EXEC: begin
               // load_PC only matters here; the PC wraps naturally at 2^PC_WIDTH.
               pc <= load_PC ? pc_value : pc + PC_WIDTH'(1);
               if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // All outputs decode registered state, so an asynchronous reset shows up at once.
   assign imem_addr   = pc;
   assign imem_en     = (state == S_FETCH);
   assign instr_valid = (state == S_ISSUE);
   assign instruction = (state == S_ISSUE) ? ir : NOP_WORD;
   assign halted      = (state == S_IDLE);

endmodule
